reg_scoreboard: RTL and testbench

- Hazard scheduler for the 15-entry Y86-64 register file, IDs 0..14; ID 4'hF = RNONE.
- Tracks outstanding writes per register. Decode-stage reads stall until all in-flight writers to that source have written back.
- Sits between decode/issue control and the register-file write-back ports. Sequences register-file access for the pipelined core.

---
 rtl/reg_scoreboard.sv | 109 ++++++++++
 tb/tb_reg_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// Register-file hazard scoreboard: per-register pending-write counters gating decode and issue.
// Optional macro SCB_WB_BYPASS_EN lets a same-cycle final write-back release the decode stall.
module reg_scoreboard #(
   parameter int NREGS = 15,
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       d_valid,
   input  logic [3:0] d_srcA,
   input  logic [3:0] d_srcB,
   output logic       d_stall,
   input  logic       iss_valid,
   input  logic [3:0] iss_dstE,
   input  logic [3:0] iss_dstM,
   output logic       iss_ready,
   input  logic       wbE_valid,
   input  logic [3:0] wbE_dst,
   input  logic       wbM_valid,
   input  logic [3:0] wbM_dst,
   output logic [5:0] pend_total,
   output logic       err
);

   localparam int SW = CNT_W + 1;
   localparam logic [SW-1:0] CMAX = SW'((1 << CNT_W) - 1);

   logic [NREGS-1:0][CNT_W-1:0] r_cnt;
   logic [5:0]                  r_total;
   logic                        r_err;

   logic [NREGS-1:0][SW-1:0]    w_inc;
   logic [NREGS-1:0][SW-1:0]    w_dec;
   logic [NREGS-1:0][CNT_W-1:0] w_cntNext;
   logic [NREGS-1:0]            w_under;
   logic                        w_full;
   logic                        w_accept;
   logic [5:0]                  w_totalNext;
   logic                        w_hzA;
   logic                        w_hzB;

   // IDs outside 0..NREGS-1 (including RNONE) never match a loop index, so they are ignored.
   always_comb begin
      w_full = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         w_inc[r] = SW'(iss_dstE == 4'(r)) + SW'(iss_dstM == 4'(r));
         w_dec[r] = SW'(wbE_valid && (wbE_dst == 4'(r))) + SW'(wbM_valid && (wbM_dst == 4'(r)));
         if ((w_inc[r] != '0) && (({1'b0, r_cnt[r]} + w_inc[r]) > (CMAX + w_dec[r])))
            w_full = 1'b1;
      end
   end

   assign iss_ready = !(iss_valid && w_full);
   assign w_accept  = iss_valid && iss_ready;

   always_comb begin : nextState
      logic [SW-1:0] sum;
      sum         = '0;
      w_under     = '0;
      w_totalNext = '0;
      for (int r = 0; r < NREGS; r++) begin
         sum = {1'b0, r_cnt[r]} + (w_accept ? w_inc[r] : '0);
         if (flush) begin
            w_cntNext[r] = '0;
         end else if (w_dec[r] > sum) begin
            w_cntNext[r] = '0;
            w_under[r]   = 1'b1;
         end else begin
            w_cntNext[r] = CNT_W'(sum - w_dec[r]);
         end
         w_totalNext = w_totalNext + 6'(w_cntNext[r]);
      end
   end

   always_comb begin
      w_hzA = 1'b0;
      w_hzB = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
`ifdef SCB_WB_BYPASS_EN
         if (d_srcA == 4'(r)) w_hzA = ({1'b0, r_cnt[r]} > w_dec[r]);
         if (d_srcB == 4'(r)) w_hzB = ({1'b0, r_cnt[r]} > w_dec[r]);
`else
         if (d_srcA == 4'(r)) w_hzA = (r_cnt[r] != '0);
         if (d_srcB == 4'(r)) w_hzB = (r_cnt[r] != '0);
`endif
      end
   end

   assign d_stall = d_valid && (w_hzA || w_hzB);

   // Flush wins over any underflow in the same cycle, so err only latches when not flushing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_total <= '0;
         r_err   <= 1'b0;
      end else begin
         r_cnt   <= w_cntNext;
         r_total <= w_totalNext;
         if (!flush && (|w_under))
            r_err <= 1'b1;
      end
   end

   assign pend_total = r_total;
   assign err        = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: driver queues expected outputs, a negedge monitor compares them.
module tb_reg_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       flush = 1'b0;
   logic       d_valid = 1'b0;
   logic [3:0] d_srcA = 4'hF;
   logic [3:0] d_srcB = 4'hF;
   logic       d_stall;
   logic       iss_valid = 1'b0;
   logic [3:0] iss_dstE = 4'hF;
   logic [3:0] iss_dstM = 4'hF;
   logic       iss_ready;
   logic       wbE_valid = 1'b0;
   logic [3:0] wbE_dst = 4'h0;
   logic       wbM_valid = 1'b0;
   logic [3:0] wbM_dst = 4'h0;
   logic [5:0] pend_total;
   logic       err;

   localparam int SIG_STALL = 0;
   localparam int SIG_READY = 1;
   localparam int SIG_TOTAL = 2;
   localparam int SIG_ERR   = 3;

`ifdef SCB_WB_BYPASS_EN
   localparam int WB_STALL = 0;
`else
   localparam int WB_STALL = 1;
`endif

   typedef struct {
      string name;
      int    sig;
      int    exp;
      int    cyc;
   } chk_t;

   chk_t q[$];
   int   cyc = 0;
   int   testsRun = 0;
   int   testsFailed = 0;

   reg_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .d_valid(d_valid), .d_srcA(d_srcA), .d_srcB(d_srcB), .d_stall(d_stall),
      .iss_valid(iss_valid), .iss_dstE(iss_dstE), .iss_dstM(iss_dstM), .iss_ready(iss_ready),
      .wbE_valid(wbE_valid), .wbE_dst(wbE_dst), .wbM_valid(wbM_valid), .wbM_dst(wbM_dst),
      .pend_total(pend_total), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Monitor: every cycle the DUT presents its outputs; pop and compare what was queued for it.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         chk_t c;
         int   act;
         c = q.pop_front();
         case (c.sig)
            SIG_STALL: act = int'(d_stall);
            SIG_READY: act = int'(iss_ready);
            SIG_TOTAL: act = int'(pend_total);
            default:   act = int'(err);
         endcase
         testsRun = testsRun + 1;
         if (act != c.exp) begin
            testsFailed = testsFailed + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", c.name, act, c.exp, cyc);
         end
      end
   end

   task automatic checkOutput(input string name, input int sig, input int exp);
      chk_t c;
      c.name = name;
      c.sig  = sig;
      c.exp  = exp;
      c.cyc  = cyc;
      q.push_back(c);
   endtask

   task automatic applyStimulus(input logic fl, input logic dv, input logic [3:0] sa, input logic [3:0] sb,
                                input logic iv, input logic [3:0] de, input logic [3:0] dm,
                                input logic ev, input logic [3:0] ed, input logic mv, input logic [3:0] md);
      @(posedge clk);
      #1;
      flush     = fl;
      d_valid   = dv;
      d_srcA    = sa;
      d_srcB    = sb;
      iss_valid = iv;
      iss_dstE  = de;
      iss_dstM  = dm;
      wbE_valid = ev;
      wbE_dst   = ed;
      wbM_valid = mv;
      wbM_dst   = md;
   endtask

   initial begin
      repeat (2) @(posedge clk);

      applyStimulus(0, 0, 4'hF, 4'hF, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      rst_n = 1'b1;
      checkOutput("rst_stall", SIG_STALL, 0);
      checkOutput("rst_ready", SIG_READY, 1);
      checkOutput("rst_total", SIG_TOTAL, 0);
      checkOutput("rst_err",   SIG_ERR,   0);

      applyStimulus(0, 1, 4'd3, 4'hF, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("idle_src3_stall", SIG_STALL, 0);

      applyStimulus(0, 1, 4'd3, 4'hF, 1, 4'd3, 4'hF, 0, 0, 0, 0);
      checkOutput("iss3_stall", SIG_STALL, 0);
      checkOutput("iss3_ready", SIG_READY, 1);

      applyStimulus(0, 1, 4'd3, 4'hF, 0, 4'hF, 4'hF, 1, 4'd3, 0, 0);
      checkOutput("r3_pend_stall", SIG_STALL, WB_STALL);
      checkOutput("r3_pend_total", SIG_TOTAL, 1);

      applyStimulus(0, 1, 4'd3, 4'hF, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("r3_done_stall", SIG_STALL, 0);
      checkOutput("r3_done_total", SIG_TOTAL, 0);

      applyStimulus(0, 1, 4'hF, 4'd4, 1, 4'd4, 4'd4, 0, 0, 0, 0);
      checkOutput("popq_ready", SIG_READY, 1);
      checkOutput("popq_stall0", SIG_STALL, 0);

      applyStimulus(0, 1, 4'hF, 4'd4, 0, 4'hF, 4'hF, 1, 4'd4, 0, 0);
      checkOutput("popq_cnt2_stall", SIG_STALL, 1);
      checkOutput("popq_cnt2_total", SIG_TOTAL, 2);

      applyStimulus(0, 1, 4'hF, 4'd4, 0, 4'hF, 4'hF, 0, 0, 1, 4'd4);
      checkOutput("popq_cnt1_stall", SIG_STALL, WB_STALL);
      checkOutput("popq_cnt1_total", SIG_TOTAL, 1);

      applyStimulus(0, 1, 4'hF, 4'd4, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("popq_done_stall", SIG_STALL, 0);
      checkOutput("popq_done_total", SIG_TOTAL, 0);

      applyStimulus(0, 0, 4'hF, 4'hF, 1, 4'd5, 4'hF, 0, 0, 0, 0);
      checkOutput("r5_iss1_ready", SIG_READY, 1);
      applyStimulus(0, 0, 4'hF, 4'hF, 1, 4'd5, 4'hF, 0, 0, 0, 0);
      checkOutput("r5_iss2_ready", SIG_READY, 1);
      checkOutput("r5_iss2_total", SIG_TOTAL, 1);
      applyStimulus(0, 0, 4'hF, 4'hF, 1, 4'd5, 4'hF, 0, 0, 0, 0);
      checkOutput("r5_iss3_ready", SIG_READY, 1);
      checkOutput("r5_iss3_total", SIG_TOTAL, 2);

      applyStimulus(0, 1, 4'd5, 4'hF, 1, 4'd5, 4'hF, 0, 0, 0, 0);
      checkOutput("r5_full_ready", SIG_READY, 0);
      checkOutput("r5_full_total", SIG_TOTAL, 3);
      checkOutput("r5_full_stall", SIG_STALL, 1);

      applyStimulus(0, 1, 4'd5, 4'hF, 1, 4'd5, 4'hF, 1, 4'd5, 0, 0);
      checkOutput("r5_wb_ready", SIG_READY, 1);
      checkOutput("r5_rej_total", SIG_TOTAL, 3);

      applyStimulus(0, 0, 4'hF, 4'hF, 1, 4'd1, 4'd2, 0, 0, 0, 0);
      checkOutput("r5_net_total", SIG_TOTAL, 3);
      checkOutput("r12_ready", SIG_READY, 1);

      applyStimulus(0, 0, 4'hF, 4'hF, 1, 4'd7, 4'hF, 0, 0, 0, 0);
      checkOutput("r12_total", SIG_TOTAL, 5);

      applyStimulus(1, 0, 4'hF, 4'hF, 1, 4'd9, 4'hF, 0, 0, 0, 0);
      checkOutput("preflush_total", SIG_TOTAL, 6);

      applyStimulus(0, 1, 4'd1, 4'd7, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("flush_total", SIG_TOTAL, 0);
      checkOutput("flush_stall_1_7", SIG_STALL, 0);

      applyStimulus(0, 1, 4'd9, 4'd5, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("flush_stall_9_5", SIG_STALL, 0);
      checkOutput("flush_err", SIG_ERR, 0);

      applyStimulus(0, 0, 4'hF, 4'hF, 0, 4'hF, 4'hF, 0, 0, 1, 4'd6);
      checkOutput("pre_under_err", SIG_ERR, 0);

      applyStimulus(0, 1, 4'd6, 4'hF, 1, 4'd8, 4'hF, 0, 0, 0, 0);
      checkOutput("under_err", SIG_ERR, 1);
      checkOutput("under_total", SIG_TOTAL, 0);
      checkOutput("under_stall6", SIG_STALL, 0);

      applyStimulus(0, 1, 4'd8, 4'hF, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      checkOutput("sticky_err", SIG_ERR, 1);
      checkOutput("r8_total", SIG_TOTAL, 1);
      checkOutput("r8_stall", SIG_STALL, 1);

      applyStimulus(0, 1, 4'd8, 4'hF, 1, 4'd8, 4'hF, 0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_stall", SIG_STALL, 0);
      checkOutput("async_rst_ready", SIG_READY, 1);
      checkOutput("async_rst_total", SIG_TOTAL, 0);
      checkOutput("async_rst_err",   SIG_ERR,   0);

      applyStimulus(0, 0, 4'hF, 4'hF, 0, 4'hF, 4'hF, 0, 0, 0, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         testsRun    = testsRun + 1;
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL drain: %0d checks pending, expected 0", q.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
